inst_axi_rd_bridge: RTL and testbench

//  Instruction-side bridge directly upstream of the IF stage. Serves the IF stage's

---
 rtl/inst_axi_rd_bridge.sv | 111 +++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side fetch bridge: sram-like req/addr_ok/data_ok port to AXI4
// single-beat reads. One registered AR slot, in-order return, bounded count
// of outstanding reads, sticky error flag for bad R beats.
module inst_axi_rd_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port from IF
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);

    localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic          ar_free;
    logic          accept;
    logic          ret;

    // Write-side inputs and RID carry no meaning for a single-ID read-only port.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid};

    // AR slot can take a new address if empty or handing its address off now.
    // The count limit uses the registered count, so a same-cycle return never
    // opens a slot early.
    assign ar_free = !arvalid || arready;
    assign accept  = inst_sram_req && !inst_sram_wr && ar_free && (cnt < CNT_MAX);
    assign rready  = (cnt != '0);
    assign ret     = rvalid && rready;

    assign inst_sram_addr_ok = accept;
    assign inst_sram_data_ok = ret;
    assign inst_sram_rdata   = rdata;

    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    // AR register: load on accept (also covers drain+refill), drop valid only on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid <= 1'b0;
            araddr  <= 32'd0;
            size_q  <= 2'd0;
        end else if (accept) begin
            arvalid <= 1'b1;
            araddr  <= inst_sram_addr;
            size_q  <= inst_sram_size;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    // Outstanding count: accepted reads not yet returned, including one still in AR.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({accept, ret})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error on any consumed beat with a bad response or missing RLAST.
    always_ff @(posedge clk) begin
        if (reset)
            rd_err <= 1'b0;
        else if (ret && (rresp != 2'b00 || !rlast))
            rd_err <= 1'b1;
    end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: directed scenarios plus a randomized run
// against a queue-based model of the IF side and a behavioural AXI slave.
module tb_inst_axi_rd_bridge;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, rd_err;

    int errors = 0;
    int checks = 0;

    inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAX), .AXI_ID(4'h0)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
        inst_sram_addr = 32'd0; inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rvalid = 1'b1; rresp = 2'b11; rlast = 1'b0;   // stray beat with nothing outstanding
        @(negedge clk);
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
        checks++; if (araddr !== 32'd0) begin errors++; $display("FAIL reset_araddr: got %h want 0", araddr); end
        checks++; if (arsize !== 3'd0) begin errors++; $display("FAIL reset_arsize: got %h want 0", arsize); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", rready); end
        checks++; if (inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok: got %b want 0", inst_sram_addr_ok); end
        checks++; if (inst_sram_data_ok !== 1'b0) begin errors++; $display("FAIL reset_stray_data_ok: got %b want 0", inst_sram_data_ok); end
        checks++; if ({arlen, arburst, arlock, arcache, arprot, arid} !== {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'h0})
            begin errors++; $display("FAIL reset_ar_consts: got %h", {arlen, arburst, arlock, arcache, arprot, arid}); end
        tick();
        @(negedge clk);
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL stray_rd_err: got %b want 0", rd_err); end
        idle();
    endtask

    task automatic test_single();
        do_reset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000; inst_sram_size = 2'd2; arready = 1'b1;
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL single_addr_ok: got %b want 1", inst_sram_addr_ok); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_t0: got %b want 0", arvalid); end
        tick();
        inst_sram_req = 1'b0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid_t1: got %b want 1", arvalid); end
        checks++; if (araddr !== 32'h1c00_0000) begin errors++; $display("FAIL single_araddr: got %h want 1c000000", araddr); end
        checks++; if (arsize !== 3'b010) begin errors++; $display("FAIL single_arsize: got %h want 2", arsize); end
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL single_rready: got %b want 1", rready); end
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (inst_sram_data_ok !== 1'b1) begin errors++; $display("FAIL single_data_ok: got %b want 1", inst_sram_data_ok); end
        checks++; if (inst_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", inst_sram_rdata); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_t2: got %b want 0", arvalid); end
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL single_cnt_zero: rready got %b want 0", rready); end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0040; inst_sram_size = 2'd2; arready = 1'b0;
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL bp_first_addr_ok: got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_addr = 32'h1c00_0044;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_0040)
                begin errors++; $display("FAIL bp_stable_%0d: got v=%b a=%h want v=1 a=1c000040", i, arvalid, araddr); end
            checks++; if (inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL bp_stall_%0d: addr_ok got %b want 0", i, inst_sram_addr_ok); end
            tick();
        end
        arready = 1'b1;
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL bp_refill_addr_ok: got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 1'b0; arready = 1'b0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_0044)
            begin errors++; $display("FAIL bp_refill_araddr: got v=%b a=%h want v=1 a=1c000044", arvalid, araddr); end
        idle();
    endtask

    task automatic test_limit();
        do_reset();
        arready = 1'b1; inst_sram_req = 1'b1; inst_sram_size = 2'd2;
        inst_sram_addr = 32'h0000_1000;
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL limit_req0: addr_ok got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_addr = 32'h0000_1004;
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL limit_req1: addr_ok got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_addr = 32'h0000_1008;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL limit_stall_%0d: addr_ok got %b want 0", i, inst_sram_addr_ok); end
            tick();
        end
        rvalid = 1'b1; rdata = 32'h1111_2222;
        @(negedge clk);
        checks++; if (inst_sram_data_ok !== 1'b1) begin errors++; $display("FAIL limit_ret: data_ok got %b want 1", inst_sram_data_ok); end
        checks++; if (inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL limit_ret_same_cycle: addr_ok got %b want 0", inst_sram_addr_ok); end
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL limit_freed: addr_ok got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_req = 1'b0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h0000_1008)
            begin errors++; $display("FAIL limit_third_ar: got v=%b a=%h want v=1 a=00001008", arvalid, araddr); end
        idle();
    endtask

    task automatic test_full_ret();
        do_reset();
        arready = 1'b1; inst_sram_req = 1'b1; inst_sram_size = 2'd2;
        inst_sram_addr = 32'h0000_2000;
        tick();
        inst_sram_addr = 32'h0000_2004;
        tick();
        // cnt is 2: request and return together
        inst_sram_addr = 32'h0000_2008; rvalid = 1'b1; rdata = 32'hAAAA_0001;
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b0 || inst_sram_data_ok !== 1'b1)
            begin errors++; $display("FAIL full_ret: got addr_ok=%b data_ok=%b want 0 1", inst_sram_addr_ok, inst_sram_data_ok); end
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL full_ret_next: addr_ok got %b want 1", inst_sram_addr_ok); end
        tick();
        inst_sram_addr = 32'h0000_200c;
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b0 || rready !== 1'b1)
            begin errors++; $display("FAIL full_again: got addr_ok=%b rready=%b want 0 1", inst_sram_addr_ok, rready); end
        idle();
    endtask

    task automatic test_error();
        do_reset();
        arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_3000; inst_sram_size = 2'd2;
        tick();
        inst_sram_req = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h0BAD_0BAD; rresp = 2'b10;
        @(negedge clk);
        checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0BAD_0BAD)
            begin errors++; $display("FAIL err_data: got ok=%b d=%h want 1 0bad0bad", inst_sram_data_ok, inst_sram_rdata); end
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL err_sticky_%0d: rd_err got %b want 1", i, rd_err); end
            tick();
        end
        // write requests are never accepted
        inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h0000_3100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (inst_sram_addr_ok !== 1'b0 || arvalid !== 1'b0)
                begin errors++; $display("FAIL err_wr_%0d: got addr_ok=%b arvalid=%b want 0 0", i, inst_sram_addr_ok, arvalid); end
            tick();
        end
        // missing RLAST alone also flags
        do_reset();
        arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_3200; inst_sram_size = 2'd2;
        tick();
        inst_sram_req = 1'b0;
        tick();
        rvalid = 1'b1; rresp = 2'b00; rlast = 1'b0;
        tick();
        rvalid = 1'b0; rlast = 1'b1;
        @(negedge clk);
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL err_rlast: rd_err got %b want 1", rd_err); end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        // leave rd_err set, then fill to the limit with AR still valid
        arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_4000; inst_sram_size = 2'd2;
        tick();
        inst_sram_req = 1'b0;
        tick();
        rvalid = 1'b1; rresp = 2'b01;
        tick();
        rvalid = 1'b0; rresp = 2'b00; inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_4010;
        tick();
        inst_sram_addr = 32'h0000_4014;
        tick();
        inst_sram_req = 1'b0; arready = 1'b0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1 || rready !== 1'b1 || rd_err !== 1'b1)
            begin errors++; $display("FAIL rmid_pre: got v=%b rr=%b err=%b want 1 1 1", arvalid, rready, rd_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || rd_err !== 1'b0 || araddr !== 32'd0)
            begin errors++; $display("FAIL rmid_post: got v=%b rr=%b err=%b a=%h want 0 0 0 0", arvalid, rready, rd_err, araddr); end
        idle();
    endtask

    task automatic test_random();
        int          outst;
        logic        err_exp, prev_stall, exp_acc, exp_dok;
        logic [31:0] prev_addr, want;
        logic [31:0] if_q[$];
        logic [31:0] sl_q[$];
        do_reset();
        outst = 0; err_exp = 1'b0; prev_stall = 1'b0; prev_addr = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            inst_sram_req  = ($urandom_range(0, 3) != 0);
            inst_sram_wr   = ($urandom_range(0, 9) == 0);
            inst_sram_addr = $urandom();
            inst_sram_addr[1:0] = 2'b00;
            inst_sram_size = 2'd2;
            arready = ($urandom_range(0, 1) == 1);
            if (sl_q.size() != 0) begin
                rvalid = ($urandom_range(0, 2) != 0);
                rdata  = slave_data(sl_q[0]);
                rresp  = ($urandom_range(0, 29) == 0) ? 2'b10 : 2'b00;
                rlast  = ($urandom_range(0, 29) != 0);
            end else if (outst == 0) begin
                rvalid = ($urandom_range(0, 3) == 0);
                rdata  = $urandom();
                rresp  = 2'b11;
                rlast  = 1'b0;
            end else begin
                rvalid = 1'b0;
                rresp  = 2'b00;
                rlast  = 1'b1;
            end
            @(negedge clk);
            exp_acc = inst_sram_req && !inst_sram_wr && (!arvalid || arready) && (outst < MAX);
            exp_dok = rvalid && (outst != 0);
            checks++; if (rready !== (outst != 0)) begin errors++; $display("FAIL rnd_rready @%0d: got %b want %b", n, rready, outst != 0); end
            checks++; if (inst_sram_addr_ok !== exp_acc) begin errors++; $display("FAIL rnd_addr_ok @%0d: got %b want %b", n, inst_sram_addr_ok, exp_acc); end
            checks++; if (inst_sram_data_ok !== exp_dok) begin errors++; $display("FAIL rnd_data_ok @%0d: got %b want %b", n, inst_sram_data_ok, exp_dok); end
            checks++; if (rd_err !== err_exp) begin errors++; $display("FAIL rnd_rd_err @%0d: got %b want %b", n, rd_err, err_exp); end
            if (prev_stall) begin
                checks++; if (arvalid !== 1'b1 || araddr !== prev_addr)
                    begin errors++; $display("FAIL rnd_ar_stable @%0d: got v=%b a=%h want v=1 a=%h", n, arvalid, araddr, prev_addr); end
            end
            if (exp_dok) begin
                want = (if_q.size() != 0) ? slave_data(if_q.pop_front()) : 32'hxxxx_xxxx;
                checks++; if (inst_sram_rdata !== want) begin errors++; $display("FAIL rnd_order @%0d: got %h want %h", n, inst_sram_rdata, want); end
                if (sl_q.size() != 0) void'(sl_q.pop_front());
                if (rresp != 2'b00 || !rlast) err_exp = 1'b1;
            end
            if (arvalid && arready) sl_q.push_back(araddr);
            prev_stall = arvalid && !arready;
            prev_addr  = araddr;
            if (exp_acc) if_q.push_back(inst_sram_addr);
            outst = outst + int'(exp_acc) - int'(exp_dok);
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_limit();
        test_full_ret();
        test_error();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
